// File: rtl/ysyx_22050612_lsu_if.sv
// rtl/ysyx_22050612_lsu_if.sv - operation, result and memory-port bundle of the ysyx_22050612 load/store unit
interface ysyx_22050612_lsu_if #(
  parameter int XLEN = 64,
  parameter int AW   = 64
);
  localparam int NB = XLEN / 8;

  logic            in_valid;
  logic            in_ready;
  logic            in_load;
  logic [1:0]      in_size;
  logic            in_unsigned;
  logic [AW-1:0]   in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [4:0]      in_rd;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rdata;
  logic [4:0]      out_rd;
  logic            out_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [NB-1:0]   mem_req_wmask;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  modport slave (
    input  in_valid, in_load, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_rdata, out_rd, out_err,
    input  out_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output in_valid, in_load, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_rdata, out_rd, out_err,
    output out_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/ysyx_22050612_lsu.sv
// rtl/ysyx_22050612_lsu.sv - multi-cycle load/store unit, one outstanding memory request
// Optional counters perf_loads/perf_stores/perf_stall enabled by YSYX_22050612_LSU_PERF_EN.
module ysyx_22050612_lsu #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic clk,
  input  logic rst,
  ysyx_22050612_lsu_if.slave bus
`ifdef YSYX_22050612_LSU_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall
`endif
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e          state_q;
  logic            load_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [OW-1:0]   off_q;

  logic            in_ready_q;
  logic            req_valid_q;
  logic            req_we_q;
  logic [AW-1:0]   req_addr_q;
  logic [XLEN-1:0] req_wdata_q;
  logic [NB-1:0]   req_wmask_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_rdata_q;
  logic [4:0]      out_rd_q;
  logic            out_err_q;

  logic [2:0]      lane_mask;
  logic [7:0]      size_mask;
  logic            acc_err;
  logic [OW-1:0]   acc_off;
  logic [NB-1:0]   acc_mask;
  logic [XLEN-1:0] acc_wdata;

  assign acc_off = bus.in_addr[OW-1:0];

  // lane_mask doubles as the alignment test and the store-data replication index mask
  always_comb begin
    lane_mask = 3'b000;
    size_mask = 8'h01;
    case (bus.in_size)
      2'd0: begin lane_mask = 3'b000; size_mask = 8'h01; end
      2'd1: begin lane_mask = 3'b001; size_mask = 8'h03; end
      2'd2: begin lane_mask = 3'b011; size_mask = 8'h0F; end
      default: begin lane_mask = 3'b111; size_mask = 8'hFF; end
    endcase
    acc_err  = (|(bus.in_addr[2:0] & lane_mask)) || (bus.in_size == 2'd3 && XLEN == 32);
    acc_mask = NB'(size_mask) << acc_off;
    acc_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      acc_wdata[8*i +: 8] = bus.in_wdata[8*(i & int'(lane_mask)) +: 8];
    end
  end

  logic [XLEN-1:0] rsp_shift;
  logic [XLEN-1:0] rsp_lmask;
  logic            rsp_sign;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    rsp_shift = bus.mem_resp_data >> {off_q, 3'b000};
    rsp_lmask = '1;
    rsp_sign  = rsp_shift[XLEN-1];
    case (size_q)
      2'd0: begin rsp_lmask = XLEN'(64'hFF);        rsp_sign = rsp_shift[7];  end
      2'd1: begin rsp_lmask = XLEN'(64'hFFFF);      rsp_sign = rsp_shift[15]; end
      2'd2: begin rsp_lmask = XLEN'(64'hFFFF_FFFF); rsp_sign = rsp_shift[31]; end
      default: begin rsp_lmask = '1;                rsp_sign = rsp_shift[XLEN-1]; end
    endcase
    ld_data = (rsp_shift & rsp_lmask) | (~rsp_lmask & {XLEN{rsp_sign & ~uns_q}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_rd_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            load_q     <= bus.in_load;
            size_q     <= bus.in_size;
            uns_q      <= bus.in_unsigned;
            off_q      <= acc_off;
            out_rd_q   <= bus.in_rd;
            in_ready_q <= 1'b0;
            if (acc_err) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_rdata_q <= '0;
            end else begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_we_q    <= ~bus.in_load;
              req_addr_q  <= {bus.in_addr[AW-1:OW], {OW{1'b0}}};
              req_wmask_q <= bus.in_load ? '0 : acc_mask;
              req_wdata_q <= bus.in_load ? '0 : acc_wdata;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b0;
            out_rdata_q <= load_q ? ld_data : '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_err       = out_err_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;

`ifdef YSYX_22050612_LSU_PERF_EN
  logic [31:0] perf_loads_q;
  logic [31:0] perf_stores_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (state_q == DONE && bus.out_ready && !out_err_q) begin
        if (load_q) perf_loads_q  <= perf_loads_q + 32'd1;
        else        perf_stores_q <= perf_stores_q + 32'd1;
      end
      if ((state_q == REQ && !bus.mem_req_ready) || state_q == WAIT) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// tb/tb_ysyx_22050612_lsu.sv - scoreboard bench for ysyx_22050612_lsu
module tb_ysyx_22050612_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050612_lsu_if #(.XLEN(64), .AW(64)) bus ();
  ysyx_22050612_lsu_if #(.XLEN(32), .AW(32)) bus32 ();

`ifdef YSYX_22050612_LSU_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_stall;
  logic [31:0] p32_loads, p32_stores, p32_stall;
`endif

  ysyx_22050612_lsu #(.XLEN(64), .AW(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef YSYX_22050612_LSU_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall)
`endif
  );

  ysyx_22050612_lsu #(.XLEN(32), .AW(32)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
`ifdef YSYX_22050612_LSU_PERF_EN
    , .perf_loads(p32_loads), .perf_stores(p32_stores), .perf_stall(p32_stall)
`endif
  );

  typedef struct {logic [63:0] rdata; logic [4:0] rd; logic err;} out_t;
  typedef struct {logic we; logic [63:0] addr; logic [7:0] mask; logic [63:0] wdata;} req_t;

  out_t        out_q[$];
  req_t        req_q[$];
  logic [63:0] resp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  bit          no_resp = 1'b0;
  bit          resp_pend = 1'b0;
  bit          late_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // result monitor
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) chk("unexpected_out_valid", 64'(1), 64'(0));
        else begin
          e = out_q.pop_front();
          chk("out_rdata", bus.out_rdata, e.rdata);
          chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
          chk("out_err", 64'(bus.out_err), 64'(e.err));
        end
        done_cnt++;
      end
    end
  end

  // request monitor: checks fields every cycle the request is presented
  initial begin
    req_t r;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_valid) begin
        if (req_q.size() == 0) chk("unexpected_mem_req", 64'(1), 64'(0));
        else begin
          r = req_q[0];
          chk("mem_req_we", 64'(bus.mem_req_we), 64'(r.we));
          chk("mem_req_addr", bus.mem_req_addr, r.addr);
          if (r.we) begin
            chk("mem_req_wmask", 64'(bus.mem_req_wmask), 64'(r.mask));
            chk("mem_req_wdata", bus.mem_req_wdata, r.wdata);
          end
          if (bus.mem_req_ready) begin
            r = req_q.pop_front();
            if (!no_resp) resp_pend = 1'b1;
          end
        end
      end
    end
  end

  // memory responder: one-cycle pulse the cycle after the request handshake
  initial begin
    forever begin
      @(posedge clk);
      if (resp_pend || late_resp) begin
        resp_pend = 1'b0;
        late_resp = 1'b0;
        #1;
        bus.mem_resp_data  = (resp_q.size() != 0) ? resp_q.pop_front() : 64'hA5A5_A5A5_A5A5_A5A5;
        bus.mem_resp_valid = 1'b1;
        @(posedge clk);
        #1 bus.mem_resp_valid = 1'b0;
      end
    end
  end

  task automatic op(input logic ld, input logic [1:0] sz, input logic uns, input logic [63:0] a,
                    input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] resp,
                    input logic [63:0] exp_rdata, input logic exp_err, input logic [7:0] exp_mask,
                    input logic [63:0] exp_wdata, input int stall, input int hold);
    out_t o;
    req_t r;
    int   lat;
    int   stall_left;
    int   base;
    bit   seen;
    o.rdata = exp_rdata; o.rd = rd; o.err = exp_err;
    out_q.push_back(o);
    if (!exp_err) begin
      r.we = ~ld; r.addr = a & ~64'h7; r.mask = exp_mask; r.wdata = exp_wdata;
      req_q.push_back(r);
      resp_q.push_back(resp);
    end
    base = done_cnt;
    lat = 0;
    @(negedge clk);
    while (!bus.in_ready && lat < 50) begin @(negedge clk); lat++; end
    chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_load = ld; bus.in_size = sz; bus.in_unsigned = uns;
    bus.in_addr = a; bus.in_wdata = wd; bus.in_rd = rd;
    bus.mem_req_ready = (stall == 0);
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0; seen = 1'b0; stall_left = stall;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else if (stall_left > 0 && bus.mem_req_valid) begin
        chk("in_ready_busy", 64'(bus.in_ready), 64'(0));
        stall_left--;
        if (stall_left == 0) begin @(posedge clk); #1 bus.mem_req_ready = 1'b1; end
      end
    end
    chk("out_valid_seen", 64'(seen), 64'(1));
    if (stall == 0) chk("latency", 64'(lat), exp_err ? 64'(1) : 64'(3));
    for (int h = 0; h < hold; h++) begin
      chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
    end
    if (hold > 0) begin @(posedge clk); #1 bus.out_ready = 1'b1; end
    lat = 0;
    while (done_cnt == base && lat < 20) begin @(negedge clk); lat++; end
    @(negedge clk);
    chk("single_completion", 64'(done_cnt - base), 64'(1));
  endtask

  initial begin
    int lat;
    req_t r;
    bus.in_valid = 0; bus.in_load = 0; bus.in_size = 0; bus.in_unsigned = 0;
    bus.in_addr = 0; bus.in_wdata = 0; bus.in_rd = 0; bus.out_ready = 1;
    bus.mem_req_ready = 1; bus.mem_resp_valid = 0; bus.mem_resp_data = 0;
    bus32.in_valid = 0; bus32.in_load = 0; bus32.in_size = 0; bus32.in_unsigned = 0;
    bus32.in_addr = 0; bus32.in_wdata = 0; bus32.in_rd = 0; bus32.out_ready = 1;
    bus32.mem_req_ready = 1; bus32.mem_resp_valid = 0; bus32.mem_resp_data = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_out_rdata", bus.out_rdata, 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // loads: ld, size, uns, addr, wdata, rd, resp, exp_rdata, err, mask, wdata, stall, hold
    op(1, 0, 0, 64'h8000_0000, 0, 5'd1, 64'h1122334455667788, 64'hFFFF_FFFF_FFFF_FF88, 0, 0, 0, 0, 0);
    op(1, 0, 1, 64'h8000_0000, 0, 5'd2, 64'h1122334455667788, 64'h88, 0, 0, 0, 0, 0);
    op(1, 2, 0, 64'h8000_0004, 0, 5'd3, 64'h1122334455667788, 64'h0000_0000_1122_3344, 0, 0, 0, 0, 0);
    op(1, 0, 0, 64'h8000_0003, 0, 5'd4, 64'h1122334455667788, 64'h55, 0, 0, 0, 0, 0);
    op(1, 1, 0, 64'h8000_0000, 0, 5'd5, 64'h0000000000008001, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 0, 0, 0);
    op(1, 1, 1, 64'h8000_0006, 0, 5'd6, 64'h8001000000000000, 64'h8001, 0, 0, 0, 0, 0);
    op(1, 2, 0, 64'h8000_0004, 0, 5'd7, 64'h89ABCDEF00000000, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 0, 0, 0);
    op(1, 2, 1, 64'h8000_0004, 0, 5'd8, 64'h89ABCDEF00000000, 64'h0000_0000_89AB_CDEF, 0, 0, 0, 0, 0);
    op(1, 3, 1, 64'h8000_0008, 0, 5'd9, 64'hFEDCBA9876543210, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0, 0);
    // stores
    op(0, 2, 0, 64'h8000_0004, 64'h12345678DEADBEEF, 5'd10, '1, 64'h0, 0, 8'hF0, 64'hDEADBEEFDEADBEEF, 0, 0);
    op(0, 0, 0, 64'h8000_0005, 64'h00000000000000AB, 5'd11, '1, 64'h0, 0, 8'h20, 64'hABABABABABABABAB, 0, 0);
    op(0, 1, 0, 64'h8000_0006, 64'h000000000000CAFE, 5'd12, '1, 64'h0, 0, 8'hC0, 64'hCAFECAFECAFECAFE, 0, 0);
    op(0, 3, 0, 64'h8000_0008, 64'h0123456789ABCDEF, 5'd13, '1, 64'h0, 0, 8'hFF, 64'h0123456789ABCDEF, 0, 0);
    // misaligned accesses
    op(1, 1, 0, 64'h8000_0001, 0, 5'd14, 0, 64'h0, 1, 0, 0, 0, 0);
    op(0, 2, 0, 64'h8000_0002, 64'h1, 5'd15, 0, 64'h0, 1, 0, 0, 0, 0);
    op(1, 3, 0, 64'h8000_0004, 0, 5'd16, 0, 64'h0, 1, 0, 0, 0, 0);
    // back-pressure on both sides
    op(1, 2, 0, 64'h8000_0010, 0, 5'd17, 64'h000000007FFF0001, 64'h7FFF_0001, 0, 0, 0, 5, 3);
`ifdef YSYX_22050612_LSU_PERF_EN
    chk("perf_stall_ge5", 64'(perf_stall >= 32'd5), 64'(1));
`endif

    // XLEN=32 rejects doubleword access
    @(posedge clk);
    #1;
    bus32.in_valid = 1; bus32.in_load = 1; bus32.in_size = 3; bus32.in_addr = 0; bus32.in_rd = 5'd20;
    @(posedge clk);
    #1 bus32.in_valid = 0;
    @(negedge clk);
    chk("x32_out_valid", 64'(bus32.out_valid), 64'(1));
    chk("x32_out_err", 64'(bus32.out_err), 64'(1));
    chk("x32_out_rdata", 64'(bus32.out_rdata), 64'(0));
    chk("x32_out_rd", 64'(bus32.out_rd), 64'(20));
    chk("x32_no_mem_req", 64'(bus32.mem_req_valid), 64'(0));

    // reset while waiting for the memory response
    no_resp = 1'b1;
    r.we = 0; r.addr = 64'h8000_0020; r.mask = 0; r.wdata = 0;
    req_q.push_back(r);
    @(posedge clk);
    #1;
    bus.in_valid = 1; bus.in_load = 1; bus.in_size = 2; bus.in_unsigned = 0;
    bus.in_addr = 64'h8000_0020; bus.in_rd = 5'd21; bus.mem_req_ready = 1; bus.out_ready = 1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    lat = 0;
    while (req_q.size() != 0 && lat < 20) begin @(posedge clk); lat++; end
    chk("rst_test_handshake", 64'(req_q.size()), 64'(0));
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wait_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("wait_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("wait_rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    late_resp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("late_resp_ignored", 64'(bus.out_valid), 64'(0));
    end
    no_resp = 1'b0;

    chk("scoreboard_drained", 64'(out_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
